rcpt_ptw: RTL and testbench
===========================

# rcpt_ptw

Page-table walker for the RCPT/cRCPT TLB. It accepts a miss request carrying the missing virtual address and fetches the aligned group of 2^PTE_LOG2 64-bit PTEs from memory, one request at a time, into a local buffer. It then drives the TLB's PTE update port, holding each PTE for the exact number of cycles the TLB's update sequencer consumes, and advances a round-robin victim index. It sits between the TLB miss path and the memory read port.

## Interface
- ADDR_WIDTH, 35, virtual/physical address width
- VPN_WIDTH, 23, VPN width; page offset is ADDR_WIDTH-VPN_WIDTH bits
- PTE_LOG2, 1, log2 of PTEs fetched per walk
- TLB_ENTRIES, 32, victim index modulus (≤32)
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_walkReq  in  1  miss request pulse; sampled only in IDLE
- i_walkVA  in  ADDR_WIDTH  missing virtual address, valid with i_walkReq
- i_ptBase  in  ADDR_WIDTH  page-table base address, quasi-static
- o_busy  out  1  high in every state except IDLE
- o_memReq  out  1  memory read request
- o_memAddr  out  ADDR_WIDTH  byte address of the requested PTE
- i_memAck  in  1  request accepted this cycle
- i_memRValid  in  1  read data valid
- i_memRData  in  64  read data (one PTE)
- i_memRErr  in  1  read error, qualified by i_memRValid
- o_ptwUpdate  out  1  PTE update strobe to TLB
- o_ptwPTE  out  64  PTE presented to TLB
- o_indexVictim  out  5  TLB line to overwrite
- o_walkErr  out  1  one-cycle pulse: walk aborted on memory error

## Operation
- States: IDLE, REQ, WAIT, DELIVER.
- IDLE: when i_walkReq=1, latch groupVPN = i_walkVA[ADDR_WIDTH-1 -: VPN_WIDTH] with its low PTE_LOG2 bits cleared; set k=0; go to REQ.
- REQ: o_memReq=1, o_memAddr = i_ptBase + ((groupVPN + k) << 3), truncated to ADDR_WIDTH. Both are held stable until i_memAck=1, then go to WAIT.
- WAIT: on i_memRValid=1 with i_memRErr=0, store the data in buf[k]. If k = 2^PTE_LOG2-1, go to DELIVER with j=0. Otherwise k++ and go to REQ.
- WAIT on i_memRValid=1 with i_memRErr=1: pulse o_walkErr, discard the buffer, go to IDLE. No o_ptwUpdate is issued for that walk.
- Only one request is outstanding at a time. i_memRValid outside WAIT is ignored.
- DELIVER: o_ptwUpdate=1 and o_ptwPTE=buf[j], held for H cycles:
  - j=0: H=4 if buf[0][63] (cRCPT), else H=3.
  - j>0: H=3 if buf[j][63], else H=2.
- PTEs are delivered back-to-back with no gap. After the last cycle of the last PTE, go to IDLE and drop o_ptwUpdate.
- o_indexVictim increments by 1 after every cycle with o_ptwUpdate=1, wrapping from TLB_ENTRIES-1 to 0. It persists across walks and is not cleared between walks.
- i_walkReq in any non-IDLE state is ignored. The requester must retry.

## Timing
- Reset values: o_busy=0, o_memReq=0, o_memAddr=0, o_ptwUpdate=0, o_ptwPTE=0, o_indexVictim=0, o_walkErr=0. State resets to IDLE, with k=j=0.
- Asserting i_rst mid-walk returns to reset values immediately (asynchronously). Data or acks arriving after reset release are ignored until a new walk is in WAIT.
- All outputs are registered.
- o_memReq rises the cycle after i_walkReq is sampled.
- i_memAck in the same cycle as o_memReq's first high cycle is legal.
- Read data must arrive ≥1 cycle after the ack.
- Zero-wait memory (ack on first req cycle, data the next cycle): each PTE costs 2 cycles. o_ptwUpdate rises 1 cycle after the last data is captured.
- o_busy covers the full walk, including the final update cycle.
- o_walkErr is asserted the cycle after the erroring data beat. o_busy drops the same cycle.

## Test plan
- Basic non-compressed walk: i_ptBase=0x1000_0000, i_walkVA=0x5000 (VPN 5), zero-wait memory returning PTEs 0x0000_0001_0000_0001 and 0x0000_0002_0000_0001 → o_memAddr sequence 0x1000_0020, 0x1000_0028. Then o_ptwUpdate high for 3+2=5 consecutive cycles with PTE0 for 3 cycles and PTE1 for 2. o_indexVictim goes 0→5.
- Compressed walk: both PTEs have bit63=1 → o_ptwUpdate high for 4+3=7 cycles. o_indexVictim advances by 7.
- Backpressure: hold i_memAck=0 for 5 cycles, data latency 3 → o_memReq and o_memAddr remain stable throughout. Delivery is identical to the first test.
- Memory error on the second beat: i_memRErr=1 → one-cycle o_walkErr, zero o_ptwUpdate cycles, o_indexVictim unchanged, back in IDLE.
- Victim wrap: start with o_indexVictim at 30, run a 5-cycle walk → value sequence 30,31,0,1,2, ending at 3.
- Reset mid-DELIVER, plus i_walkReq while busy: assert i_rst at cycle 2 of delivery → all outputs 0 at once. A walk request issued during REQ is ignored, and o_memAddr is unaffected.

Source files
------------

// File: rtl/rcpt_ptw_if.sv
// Bus bundle for the RCPT page-table walker: miss request from the TLB,
// memory read port and PTE update port back to the TLB.
// Handshakes: a miss is a single-cycle pulse on i_walkReq that is taken only
// while the walker is idle. A memory read is offered by holding o_memReq and
// o_memAddr stable until i_memAck is seen high at a clock edge; exactly one
// read is outstanding, and its reply is the single cycle with i_memRValid
// high (i_memRErr is only meaningful in that cycle).
interface rcpt_ptw_if #(
  parameter int ADDR_WIDTH = 35
);
  logic                  i_walkReq;
  logic [ADDR_WIDTH-1:0] i_walkVA;
  logic [ADDR_WIDTH-1:0] i_ptBase;
  logic                  o_busy;
  logic                  o_memReq;
  logic [ADDR_WIDTH-1:0] o_memAddr;
  logic                  i_memAck;
  logic                  i_memRValid;
  logic [63:0]           i_memRData;
  logic                  i_memRErr;
  logic                  o_ptwUpdate;
  logic [63:0]           o_ptwPTE;
  logic [4:0]            o_indexVictim;
  logic                  o_walkErr;
  logic [1:0]            o_dbgState;

  modport slave (
    input  i_walkReq, i_walkVA, i_ptBase, i_memAck, i_memRValid, i_memRData, i_memRErr,
    output o_busy, o_memReq, o_memAddr, o_ptwUpdate, o_ptwPTE, o_indexVictim, o_walkErr,
    output o_dbgState
  );

  modport master (
    output i_walkReq, i_walkVA, i_ptBase, i_memAck, i_memRValid, i_memRData, i_memRErr,
    input  o_busy, o_memReq, o_memAddr, o_ptwUpdate, o_ptwPTE, o_indexVictim, o_walkErr,
    input  o_dbgState
  );
endinterface

// File: rtl/rcpt_ptw.sv
// Page-table walker: fetches the aligned group of PTEs covering a missing VA,
// one read at a time, then streams them into the TLB update port, holding
// each PTE for as many cycles as the TLB's update sequencer needs for it.
// o_dbgState exposes the FSM state (0 IDLE, 1 REQ, 2 WAIT, 3 DELIVER).
module rcpt_ptw #(
  parameter int ADDR_WIDTH  = 35,
  parameter int VPN_WIDTH   = 23,
  parameter int PTE_LOG2    = 1,
  parameter int TLB_ENTRIES = 32
) (
  input  logic      i_clk,
  input  logic      i_rst,
  rcpt_ptw_if.slave bus
);

  localparam int NPTE = 1 << PTE_LOG2;
  localparam int KW   = (PTE_LOG2 > 0) ? PTE_LOG2 : 1;
  localparam logic [KW-1:0]        K_LAST   = KW'(NPTE - 1);
  localparam logic [VPN_WIDTH-1:0] GRP_MASK = ~VPN_WIDTH'(NPTE - 1);
  localparam logic [4:0]           VIC_LAST = 5'(TLB_ENTRIES - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DELIVER} state_t;

  state_t                state_q, state_d;
  logic [VPN_WIDTH-1:0]  vpn_q, vpn_d;
  logic [KW-1:0]         k_q, k_d;
  logic [KW-1:0]         j_q, j_d;
  logic [2:0]            hold_q, hold_d;
  logic                  busy_q, busy_d;
  logic                  mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  upd_q, upd_d;
  logic [63:0]           pte_q, pte_d;
  logic [4:0]            victim_q, victim_d;
  logic                  err_q, err_d;
  logic [63:0]           pte_buf_q [NPTE];
  logic [63:0]           pte_buf_d [NPTE];

  // Byte address of PTE (group base + idx); wraps at ADDR_WIDTH bits.
  function automatic logic [ADDR_WIDTH-1:0] pte_addr(input logic [ADDR_WIDTH-1:0] base,
                                                     input logic [VPN_WIDTH-1:0]  vpn,
                                                     input logic [KW-1:0]         idx);
    logic [ADDR_WIDTH-1:0] off;
    off = ADDR_WIDTH'(vpn) + ADDR_WIDTH'(idx);
    return base + (off << 3);
  endfunction

  // Update-sequencer occupancy: the first PTE of a walk costs one extra cycle,
  // and a compressed (bit 63) PTE costs one more.
  function automatic logic [2:0] hold_of(input logic [63:0] pte, input logic first);
    logic [2:0] h;
    h = first ? 3'd3 : 3'd2;
    if (pte[63]) h = h + 3'd1;
    return h;
  endfunction

  // Next-state and next-output logic for the whole walker.
  always_comb begin
    state_d    = state_q;
    vpn_d      = vpn_q;
    k_d        = k_q;
    j_d        = j_q;
    hold_d     = hold_q;
    busy_d     = busy_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    upd_d      = upd_q;
    pte_d      = pte_q;
    victim_d   = victim_q;
    err_d      = 1'b0;
    pte_buf_d  = pte_buf_q;

    // Victim pointer advances once per cycle the TLB is being written.
    if (upd_q) begin
      victim_d = (victim_q == VIC_LAST) ? 5'd0 : victim_q + 5'd1;
    end

    case (state_q)
      IDLE: begin
        if (bus.i_walkReq) begin
          vpn_d      = bus.i_walkVA[ADDR_WIDTH-1 -: VPN_WIDTH] & GRP_MASK;
          k_d        = '0;
          j_d        = '0;
          busy_d     = 1'b1;
          mem_req_d  = 1'b1;
          mem_addr_d = pte_addr(bus.i_ptBase, vpn_d, '0);
          state_d    = REQ;
        end
      end
      REQ: begin
        if (bus.i_memAck) begin
          mem_req_d = 1'b0;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (bus.i_memRValid) begin
          if (bus.i_memRErr) begin
            for (int i = 0; i < NPTE; i++) pte_buf_d[i] = '0;
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            pte_buf_d[k_q] = bus.i_memRData;
            if (k_q == K_LAST) begin
              j_d     = '0;
              upd_d   = 1'b1;
              pte_d   = pte_buf_d[0];
              hold_d  = hold_of(pte_d, 1'b1);
              state_d = DELIVER;
            end else begin
              k_d        = k_q + KW'(1);
              mem_req_d  = 1'b1;
              mem_addr_d = pte_addr(bus.i_ptBase, vpn_q, k_d);
              state_d    = REQ;
            end
          end
        end
      end
      DELIVER: begin
        if (hold_q == 3'd1) begin
          if (j_q == K_LAST) begin
            upd_d   = 1'b0;
            pte_d   = '0;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            j_d    = j_q + KW'(1);
            pte_d  = pte_buf_q[j_d];
            hold_d = hold_of(pte_d, 1'b0);
          end
        end else begin
          hold_d = hold_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      vpn_q      <= '0;
      k_q        <= '0;
      j_q        <= '0;
      hold_q     <= '0;
      busy_q     <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      upd_q      <= 1'b0;
      pte_q      <= '0;
      victim_q   <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < NPTE; i++) pte_buf_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      vpn_q      <= vpn_d;
      k_q        <= k_d;
      j_q        <= j_d;
      hold_q     <= hold_d;
      busy_q     <= busy_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      upd_q      <= upd_d;
      pte_q      <= pte_d;
      victim_q   <= victim_d;
      err_q      <= err_d;
      for (int i = 0; i < NPTE; i++) pte_buf_q[i] <= pte_buf_d[i];
    end
  end

  assign bus.o_busy        = busy_q;
  assign bus.o_memReq      = mem_req_q;
  assign bus.o_memAddr     = mem_addr_q;
  assign bus.o_ptwUpdate   = upd_q;
  assign bus.o_ptwPTE      = pte_q;
  assign bus.o_indexVictim = victim_q;
  assign bus.o_walkErr     = err_q;
  assign bus.o_dbgState    = state_q;

endmodule

// File: tb/tb_rcpt_ptw.sv
// Self-checking bench for rcpt_ptw: drives walks against a scripted memory,
// predicts the address sequence and every update cycle (PTE and victim index)
// into queues, and compares as the DUT produces them.
module tb_rcpt_ptw;

  logic clk;
  logic rst;

  rcpt_ptw_if #(.ADDR_WIDTH(35)) bus ();

  rcpt_ptw #(
    .ADDR_WIDTH(35), .VPN_WIDTH(23), .PTE_LOG2(1), .TLB_ENTRIES(32)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard
  logic [34:0] exp_addr_q[$];
  logic [68:0] exp_upd_q[$];   // {victim[4:0], pte[63:0]}
  logic [4:0]  exp_victim;
  int          n_checks;
  int          n_fail;
  bit          mon_en;

  task automatic check(input string tag, input logic [68:0] got, input logic [68:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Predict the update cycles for one complete walk.
  task automatic push_updates(input logic [63:0] p0, input logic [63:0] p1);
    logic [63:0] p;
    int h;
    for (int j = 0; j < 2; j++) begin
      p = (j == 0) ? p0 : p1;
      if (j == 0) h = p[63] ? 4 : 3;
      else        h = p[63] ? 3 : 2;
      for (int c = 0; c < h; c++) begin
        exp_upd_q.push_back({exp_victim, p});
        exp_victim = (exp_victim == 5'd31) ? 5'd0 : exp_victim + 5'd1;
      end
    end
  endtask

  // Update-port monitor
  always @(negedge clk) begin
    logic [68:0] e;
    if (mon_en && !rst && bus.o_ptwUpdate) begin
      if (exp_upd_q.size() == 0) begin
        check("upd_extra", {68'd0, bus.o_ptwUpdate}, 69'd0);
      end else begin
        e = exp_upd_q.pop_front();
        check("upd_pte", {5'd0, bus.o_ptwPTE}, {5'd0, e[63:0]});
        check("upd_victim", {64'd0, bus.o_indexVictim}, {64'd0, e[68:64]});
      end
    end
  end

  // One walk. err_beat < 0 means no error; busy_req pulses a second miss
  // while the first read is pending; rst_dlv resets on delivery cycle 2.
  task automatic do_walk(input logic [34:0] va, input logic [63:0] p0, input logic [63:0] p1,
                         input int ack_dly, input int lat, input int err_beat,
                         input bit busy_req, input bit rst_dlv);
    logic [22:0] grp;
    logic [34:0] a;
    logic [34:0] a0;
    logic [34:0] ea;
    int beats;
    int cnt;
    grp   = va[34:12] & ~23'd1;
    beats = (err_beat >= 0) ? err_beat + 1 : 2;
    for (int b = 0; b < beats; b++) begin
      a = bus.i_ptBase + (35'({12'd0, grp} + 35'(b)) << 3);
      exp_addr_q.push_back(a);
    end
    if (rst_dlv) mon_en = 1'b0;
    else if (err_beat < 0) push_updates(p0, p1);

    bus.i_walkReq = 1'b1;
    bus.i_walkVA  = va;
    @(negedge clk);
    bus.i_walkReq = 1'b0;
    check("memreq_rise", {68'd0, bus.o_memReq}, 69'd1);
    check("busy_rise", {68'd0, bus.o_busy}, 69'd1);

    for (int b = 0; b < beats; b++) begin
      cnt = 0;
      while (!bus.o_memReq && cnt < 50) begin
        @(negedge clk);
        cnt++;
      end
      check("memreq_wait", {68'd0, bus.o_memReq}, 69'd1);
      a0 = bus.o_memAddr;
      ea = exp_addr_q.pop_front();
      check("mem_addr", {34'd0, a0}, {34'd0, ea});
      for (int d = 0; d < ack_dly; d++) begin
        if (busy_req && b == 0 && d == 0) begin
          bus.i_walkReq = 1'b1;
          bus.i_walkVA  = 35'h7_ff00_0000;
        end
        @(negedge clk);
        bus.i_walkReq = 1'b0;
        bus.i_walkVA  = va;
        check("memreq_hold", {68'd0, bus.o_memReq}, 69'd1);
        check("memaddr_hold", {34'd0, bus.o_memAddr}, {34'd0, a0});
      end
      bus.i_memAck = 1'b1;
      @(negedge clk);
      bus.i_memAck = 1'b0;
      check("memreq_drop", {68'd0, bus.o_memReq}, 69'd0);
      for (int d = 1; d < lat; d++) @(negedge clk);
      bus.i_memRValid = 1'b1;
      bus.i_memRData  = (b == 0) ? p0 : p1;
      bus.i_memRErr   = (b == err_beat);
      @(negedge clk);
      bus.i_memRValid = 1'b0;
      bus.i_memRErr   = 1'b0;
      bus.i_memRData  = '0;
    end

    if (err_beat >= 0) begin
      check("walk_err", {68'd0, bus.o_walkErr}, 69'd1);
      check("err_busy", {68'd0, bus.o_busy}, 69'd0);
      check("err_victim", {64'd0, bus.o_indexVictim}, {64'd0, exp_victim});
      @(negedge clk);
      check("walk_err_pulse", {68'd0, bus.o_walkErr}, 69'd0);
      check("err_no_upd", {68'd0, bus.o_ptwUpdate}, 69'd0);
    end else if (rst_dlv) begin
      check("rst_dlv_c1", {68'd0, bus.o_ptwUpdate}, 69'd1);
      @(negedge clk);
      check("rst_dlv_c2", {68'd0, bus.o_ptwUpdate}, 69'd1);
      rst = 1'b1;
      #1;
      check("rst_busy", {68'd0, bus.o_busy}, 69'd0);
      check("rst_upd", {68'd0, bus.o_ptwUpdate}, 69'd0);
      check("rst_pte", {5'd0, bus.o_ptwPTE}, 69'd0);
      check("rst_victim", {64'd0, bus.o_indexVictim}, 69'd0);
      check("rst_memreq", {68'd0, bus.o_memReq}, 69'd0);
      check("rst_memaddr", {34'd0, bus.o_memAddr}, 69'd0);
      check("rst_err", {68'd0, bus.o_walkErr}, 69'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_victim = 5'd0;
      // Stray beats after reset release must be ignored.
      bus.i_memAck    = 1'b1;
      bus.i_memRValid = 1'b1;
      bus.i_memRData  = 64'hdead_beef_0000_0001;
      @(negedge clk);
      bus.i_memAck    = 1'b0;
      bus.i_memRValid = 1'b0;
      bus.i_memRData  = '0;
      @(negedge clk);
      check("stray_busy", {68'd0, bus.o_busy}, 69'd0);
      check("stray_upd", {68'd0, bus.o_ptwUpdate}, 69'd0);
      check("stray_memreq", {68'd0, bus.o_memReq}, 69'd0);
      mon_en = 1'b1;
    end else begin
      check("upd_rise", {68'd0, bus.o_ptwUpdate}, 69'd1);
      cnt = 0;
      while (bus.o_busy && cnt < 100) begin
        @(negedge clk);
        cnt++;
      end
      check("busy_drop", {68'd0, bus.o_busy}, 69'd0);
      check("upd_drop", {68'd0, bus.o_ptwUpdate}, 69'd0);
      check("upd_left", 69'(exp_upd_q.size()), 69'd0);
      check("victim_end", {64'd0, bus.o_indexVictim}, {64'd0, exp_victim});
    end
    @(negedge clk);
  endtask

  localparam logic [63:0] P_N0 = 64'h0000_0001_0000_0001;
  localparam logic [63:0] P_N1 = 64'h0000_0002_0000_0001;
  localparam logic [63:0] P_C0 = 64'h8000_0001_0000_0001;
  localparam logic [63:0] P_C1 = 64'h8000_0002_0000_0001;

  // Main sequence
  initial begin
    n_checks        = 0;
    n_fail          = 0;
    mon_en          = 1'b1;
    exp_victim      = 5'd0;
    rst             = 1'b1;
    bus.i_walkReq   = 1'b0;
    bus.i_walkVA    = '0;
    bus.i_ptBase    = 35'h1000_0000;
    bus.i_memAck    = 1'b0;
    bus.i_memRValid = 1'b0;
    bus.i_memRData  = '0;
    bus.i_memRErr   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("init_busy", {68'd0, bus.o_busy}, 69'd0);
    check("init_memreq", {68'd0, bus.o_memReq}, 69'd0);
    check("init_memaddr", {34'd0, bus.o_memAddr}, 69'd0);
    check("init_upd", {68'd0, bus.o_ptwUpdate}, 69'd0);
    check("init_pte", {5'd0, bus.o_ptwPTE}, 69'd0);
    check("init_victim", {64'd0, bus.o_indexVictim}, 69'd0);
    check("init_err", {68'd0, bus.o_walkErr}, 69'd0);
    check("init_state", {67'd0, bus.o_dbgState}, 69'd0);

    do_walk(35'h5000, P_N0, P_N1, 0, 1, -1, 1'b0, 1'b0);   // basic
    check("t1_victim", {64'd0, bus.o_indexVictim}, 69'd5);
    do_walk(35'h7000, P_C0, P_C1, 0, 1, -1, 1'b0, 1'b0);   // compressed
    check("t2_victim", {64'd0, bus.o_indexVictim}, 69'd12);
    do_walk(35'h5000, P_N0, P_N1, 5, 3, -1, 1'b0, 1'b0);   // backpressure
    do_walk(35'h9000, P_N0, P_N1, 0, 1, 1, 1'b0, 1'b0);    // error on beat 1
    check("t4_victim", {64'd0, bus.o_indexVictim}, 69'd17);
    do_walk(35'h2_3456_7000, P_C0, P_C1, 1, 2, -1, 1'b0, 1'b0);
    do_walk(35'h0_0000_3000, P_C0, P_N1, 2, 1, -1, 1'b0, 1'b0);
    check("pre_wrap_victim", {64'd0, bus.o_indexVictim}, 69'd30);
    do_walk(35'h5000, P_N0, P_N1, 0, 1, -1, 1'b0, 1'b0);   // victim wrap
    check("wrap_victim", {64'd0, bus.o_indexVictim}, 69'd3);
    do_walk(35'h5000, P_N0, P_N1, 3, 1, -1, 1'b1, 1'b1);   // reset mid-deliver
    do_walk(35'hb000, P_N0, P_C1, 0, 1, -1, 1'b0, 1'b0);   // after reset
    check("final_victim", {64'd0, bus.o_indexVictim}, 69'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
